// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared state encodings, default symbols and width helper for the phy receive path
package phy_pkg;

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_ALIGN  = 2'd1;
   localparam logic [1:0] ST_SYNCED = 2'd2;

   localparam logic [7:0] COM_DEFAULT  = 8'hBC;
   localparam logic [7:0] IDLE_DEFAULT = 8'h7C;

   // Never returns 0 so a single-lane or tiny counter still gets a legal vector.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/phy_sym_align.sv
// rtl/phy_sym_align.sv - bit-sliding COM search, symbol boundary tracking and lock FSM
module phy_sym_align
   import phy_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter logic [DATA_W-1:0] COM        = DATA_W'(COM_DEFAULT),
   parameter int                SYNC_COUNT = 4
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic              serial_in,
   output logic [DATA_W-1:0] sym,
   output logic              sym_strobe,
   output logic [1:0]        state
);

   localparam int BW = clog2_min1(DATA_W);
   localparam int CW = clog2_min1(SYNC_COUNT + 1);
   localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_W - 1);
   localparam logic [CW-1:0] SYNC_TARGET = CW'(SYNC_COUNT);

   // Only the newest DATA_W-1 bits are needed; the incoming bit completes the candidate.
   logic [DATA_W-2:0] sh;
   logic [BW-1:0]     bit_cnt;
   logic [CW-1:0]     com_cnt;
   logic              boundary;
   logic              is_com;

   assign sym        = {sh, serial_in};
   assign boundary   = (bit_cnt == LAST_BIT);
   assign is_com     = (sym == COM);
   assign sym_strobe = (state == ST_SYNCED) && boundary;

   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         sh      <= '0;
         bit_cnt <= '0;
         com_cnt <= '0;
         state   <= ST_SEARCH;
      end else begin
         sh      <= sym[DATA_W-2:0];
         bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
         case (state)
            ST_SEARCH: begin
               if (is_com) begin
                  bit_cnt <= '0;
                  com_cnt <= CW'(1);
                  state   <= (SYNC_COUNT == 1) ? ST_SYNCED : ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               if (boundary) begin
                  if (is_com) begin
                     com_cnt <= com_cnt + 1'b1;
                     if (com_cnt + 1'b1 == SYNC_TARGET) state <= ST_SYNCED;
                  end else begin
                     com_cnt <= '0;
                     state   <= ST_SEARCH;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/phy_rx_sync_deser.sv
// rtl/phy_rx_sync_deser.sv - serial receive front end: symbol lock plus round-robin lane distribution
module phy_rx_sync_deser
   import phy_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                NUM_LANES  = 4,
   parameter logic [DATA_W-1:0] COM        = DATA_W'(COM_DEFAULT),
   parameter logic [DATA_W-1:0] IDLE       = DATA_W'(IDLE_DEFAULT),
   parameter int                SYNC_COUNT = 4
) (
   input  logic                          clk_32f,
   input  logic                          reset,
   input  logic                          serial_in,
   output logic [NUM_LANES*DATA_W-1:0]   data_out,
   output logic [NUM_LANES-1:0]          valid_out,
   output logic                          active,
   output logic [1:0]                    sync_state
);

   localparam int LW = clog2_min1(NUM_LANES);
   localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

   logic [DATA_W-1:0] sym;
   logic              sym_strobe;
   logic [1:0]        state;
   logic [LW-1:0]     lane_ptr;

   phy_sym_align #(
      .DATA_W     (DATA_W),
      .COM        (COM),
      .SYNC_COUNT (SYNC_COUNT)
   ) u_align (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .serial_in  (serial_in),
      .sym        (sym),
      .sym_strobe (sym_strobe),
      .state      (state)
   );

   assign sync_state = state;
   assign active     = (state == ST_SYNCED);

   // COM re-frames the lane rotation; IDLE is filler and consumes no lane.
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         lane_ptr  <= '0;
         data_out  <= '0;
         valid_out <= '0;
      end else begin
         valid_out <= '0;
         if (!active) begin
            lane_ptr <= '0;
         end else if (sym_strobe) begin
            if (sym == COM) begin
               lane_ptr <= '0;
            end else if (sym != IDLE) begin
               data_out[lane_ptr*DATA_W +: DATA_W] <= sym;
               valid_out[lane_ptr]                 <= 1'b1;
               lane_ptr <= (lane_ptr == LAST_LANE) ? '0 : lane_ptr + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_phy_rx_sync_deser.sv
// tb/tb_phy_rx_sync_deser.sv - randomized and directed bench with an offline stream-scanning reference model
module tb_phy_rx_sync_deser;

   localparam int MAXT = 1024;
   localparam int SC   = 4;
   localparam logic [7:0] COM_A  = 8'hBC;
   localparam logic [7:0] IDLE_A = 8'h7C;
   localparam logic [9:0] COM_B  = 10'h17C;
   localparam logic [9:0] IDLE_B = 10'h305;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1, rst_b = 1'b1, ser_a = 1'b0, ser_b = 1'b0;
   logic [31:0] data_a;
   logic [3:0]  valid_a;
   logic        act_a;
   logic [1:0]  st_a;
   logic [29:0] data_b;
   logic [2:0]  valid_b;
   logic        act_b;
   logic [1:0]  st_b;

   phy_rx_sync_deser dut_a (
      .clk_32f(clk), .reset(rst_a), .serial_in(ser_a),
      .data_out(data_a), .valid_out(valid_a), .active(act_a), .sync_state(st_a)
   );

   phy_rx_sync_deser #(
      .DATA_W(10), .NUM_LANES(3), .COM(COM_B), .IDLE(IDLE_B), .SYNC_COUNT(SC)
   ) dut_b (
      .clk_32f(clk), .reset(rst_b), .serial_in(ser_b),
      .data_out(data_b), .valid_out(valid_b), .active(act_b), .sync_state(st_b)
   );

   int          cfg = 0;
   int          cur_t = 0;
   bit          chk_en = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          stim[$];
   int          exp_state[MAXT];
   int          exp_valid[MAXT];
   int          exp_lane[MAXT];
   int          exp_sym[MAXT];
   logic [39:0] exp_data[MAXT];
   int          first_active;
   int          ev_t[$];
   int          ev_v[$];
   int          qt[$];
   int          qv[$];

   logic [39:0] dut_data;
   int          dut_valid;
   int          dut_state;
   logic        dut_active;

   always_comb begin
      dut_data   = 40'(data_a);
      dut_valid  = int'(valid_a);
      dut_state  = int'(st_a);
      dut_active = act_a;
      if (cfg == 1) begin
         dut_data   = 40'(data_b);
         dut_valid  = int'(valid_b);
         dut_state  = int'(st_b);
         dut_active = act_b;
      end
   end

   task automatic chk(input string name, input int t, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cfg=%0d t=%0d got=%h want=%h", name, cfg, t, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("data_out", cur_t, dut_data, exp_data[cur_t]);
         chk("valid_out", cur_t, 40'(dut_valid), 40'(exp_valid[cur_t]));
         chk("sync_state", cur_t, 40'(dut_state), 40'(exp_state[cur_t]));
         chk("active", cur_t, 40'(dut_active), 40'(exp_state[cur_t] == 2));
      end
   end

   function automatic int sym_w(input int c);
      return (c == 1) ? 10 : 8;
   endfunction

   function automatic int com_of(input int c);
      return (c == 1) ? int'(COM_B) : int'(COM_A);
   endfunction

   function automatic int idle_of(input int c);
      return (c == 1) ? int'(IDLE_B) : int'(IDLE_A);
   endfunction

   // Symbol ending at bit t, MSB first; bits before the stream start read as zero.
   function automatic int win(input int t, input int w);
      int v;
      v = 0;
      for (int j = t - w + 1; j <= t; j++) v = (v << 1) | ((j >= 0) ? stim[j] : 0);
      return v;
   endfunction

   function automatic void push_sym(input int v, input int w);
      for (int i = w - 1; i >= 0; i--) stim.push_back((v >> i) & 1);
   endfunction

   function automatic void push_rand_bits(input int n);
      for (int i = 0; i < n; i++) stim.push_back(int'($urandom_range(0, 1)));
   endfunction

   function automatic int rand_sym(input int c);
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) return com_of(c);
      if (r == 1) return idle_of(c);
      return int'($urandom_range(0, (1 << sym_w(c)) - 1));
   endfunction

   // Scans the whole stream offline: find a COM anywhere, then demand COMs every W bits.
   task automatic build_model(input int c, input int n);
      int w, l, comv, idlev, lock, s, m, b, k, lane;
      bit done, fail;
      int lane_val[4];
      logic [39:0] pk;
      w = sym_w(c);
      l = (c == 1) ? 3 : 4;
      comv = com_of(c);
      idlev = idle_of(c);
      lock = -1;
      s = 0;
      done = 1'b0;
      for (int t = 0; t < n; t++) begin
         exp_state[t] = 0;
         exp_valid[t] = 0;
         exp_lane[t] = 0;
         exp_sym[t] = 0;
      end
      while (!done && lock < 0) begin
         m = -1;
         for (int t = s; t < n; t++) begin
            if (win(t, w) == comv) begin
               m = t;
               break;
            end
         end
         if (m < 0) begin
            done = 1'b1;
         end else begin
            b = m;
            k = 1;
            fail = 1'b0;
            while (k < SC && !fail && !done) begin
               b = m + k * w;
               if (b >= n) begin
                  for (int t = m; t < n; t++) exp_state[t] = 1;
                  done = 1'b1;
               end else if (win(b, w) != comv) begin
                  for (int t = m; t < b; t++) exp_state[t] = 1;
                  s = b + 1;
                  fail = 1'b1;
               end else begin
                  k++;
               end
            end
            if (!fail && !done) begin
               lock = b;
               for (int t = m; t < b; t++) exp_state[t] = 1;
            end
         end
      end
      if (lock >= 0) begin
         for (int t = lock; t < n; t++) exp_state[t] = 2;
         lane = 0;
         for (int t = lock + w; t < n; t += w) begin
            if (win(t, w) == comv) begin
               lane = 0;
            end else if (win(t, w) != idlev) begin
               exp_valid[t] = 1 << lane;
               exp_lane[t] = lane;
               exp_sym[t] = win(t, w);
               lane = (lane + 1) % l;
            end
         end
      end
      for (int i = 0; i < 4; i++) lane_val[i] = 0;
      for (int t = 0; t < n; t++) begin
         if (exp_valid[t] != 0) lane_val[exp_lane[t]] = exp_sym[t];
         pk = '0;
         for (int i = 0; i < l; i++)
            for (int j = 0; j < w; j++) pk[i*w+j] = logic'((lane_val[i] >> j) & 1);
         exp_data[t] = pk;
      end
   endtask

   task automatic set_ser(input int c, input int v);
      if (c == 1) ser_b = v[0];
      else ser_a = v[0];
   endtask

   task automatic set_rst(input int c, input logic v);
      if (c == 1) rst_b = v;
      else rst_a = v;
   endtask

   task automatic check_zero(input string name);
      chk({name, "_data"}, -1, dut_data, '0);
      chk({name, "_valid"}, -1, 40'(dut_valid), '0);
      chk({name, "_state"}, -1, 40'(dut_state), '0);
      chk({name, "_active"}, -1, 40'(dut_active), '0);
   endtask

   task automatic run(input int c, input int abort_at);
      int n;
      n = stim.size();
      if (n > MAXT) n = MAXT;
      build_model(c, n);
      cfg = c;
      set_rst(c, 1'b1);
      set_ser(c, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      first_active = -1;
      ev_t.delete();
      ev_v.delete();
      set_ser(c, stim[0]);
      set_rst(c, 1'b0);
      for (int t = 0; t < n; t++) begin
         @(posedge clk);
         cur_t = t;
         chk_en = 1'b1;
         @(negedge clk);
         if (dut_active && first_active < 0) first_active = t;
         if (dut_valid != 0) begin
            ev_t.push_back(t);
            ev_v.push_back(dut_valid);
         end
         if (t == abort_at) begin
            #1;
            chk_en = 1'b0;
            set_rst(c, 1'b1);
            #1;
            check_zero("async_reset");
            break;
         end
         if (t + 1 < n) set_ser(c, stim[t+1]);
      end
      #1;
      chk_en = 1'b0;
   endtask

   task automatic check_events(input string name);
      chk({name, "_count"}, -1, 40'(ev_t.size()), 40'(qt.size()));
      for (int i = 0; i < qt.size(); i++) begin
         if (i < ev_t.size()) begin
            chk({name, "_time"}, i, 40'(ev_t[i]), 40'(qt[i]));
            chk({name, "_lanes"}, i, 40'(ev_v[i]), 40'(qv[i]));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout cfg=%0d t=%0d", cfg, cur_t);
      $fatal(1, "watchdog");
   end

   initial begin
      // 4 COMs then four data symbols across all lanes
      stim.delete();
      repeat (4) push_sym(COM_A, 8);
      push_sym(8'h11, 8); push_sym(8'h22, 8); push_sym(8'h33, 8); push_sym(8'h44, 8);
      push_sym(IDLE_A, 8); push_sym(IDLE_A, 8);
      run(0, -1);
      chk("s1_active_rise", -1, 40'(first_active), 40'd31);
      qt = '{39, 47, 55, 63}; qv = '{1, 2, 4, 8};
      check_events("s1");
      chk("s1_data_final", -1, dut_data, 40'h44332211);

      // misaligned prefix
      stim.delete();
      push_rand_bits(3);
      repeat (4) push_sym(COM_A, 8);
      push_sym(8'hA5, 8); push_sym(IDLE_A, 8);
      run(0, -1);
      chk("s2_active_rise", -1, 40'(first_active), 40'd34);
      qt = '{42}; qv = '{1};
      check_events("s2");
      chk("s2_data_final", -1, dut_data, 40'hA5);

      // broken COM run falls back to search
      stim.delete();
      repeat (2) push_sym(COM_A, 8);
      push_sym(8'h55, 8);
      repeat (4) push_sym(COM_A, 8);
      push_sym(8'h66, 8); push_sym(IDLE_A, 8);
      run(0, -1);
      chk("s3_active_rise", -1, 40'(first_active), 40'd55);
      qt = '{63}; qv = '{1};
      check_events("s3");

      // IDLE skipped, COM re-frames to lane 0
      stim.delete();
      repeat (4) push_sym(COM_A, 8);
      push_sym(8'h01, 8); push_sym(IDLE_A, 8); push_sym(8'h02, 8);
      push_sym(COM_A, 8); push_sym(8'h03, 8); push_sym(IDLE_A, 8);
      run(0, -1);
      qt = '{39, 55, 71}; qv = '{1, 2, 1};
      check_events("s4");
      chk("s4_data_final", -1, dut_data, 40'h0203);

      // 10-bit symbols, 3 lanes: lane 0 wraps and is overwritten
      stim.delete();
      repeat (4) push_sym(COM_B, 10);
      push_sym(1, 10); push_sym(2, 10); push_sym(3, 10); push_sym(4, 10);
      push_sym(IDLE_B, 10);
      run(1, -1);
      chk("s5_active_rise", -1, 40'(first_active), 40'd39);
      qt = '{49, 59, 69, 79}; qv = '{1, 2, 4, 1};
      check_events("s5");
      chk("s5_data_final", -1, dut_data, 40'h300804);

      // reset mid-symbol while synced, then relock needs a fresh full COM run
      stim.delete();
      repeat (4) push_sym(COM_A, 8);
      push_sym(8'h11, 8); push_sym(8'h22, 8);
      run(0, 43);
      stim.delete();
      repeat (3) push_sym(COM_A, 8);
      push_sym(8'h99, 8);
      repeat (4) push_sym(COM_A, 8);
      push_sym(8'h12, 8); push_sym(IDLE_A, 8);
      run(0, -1);
      chk("s6_active_rise", -1, 40'(first_active), 40'd63);
      qt = '{71}; qv = '{1};
      check_events("s6");

      // randomized streams on both configurations
      for (int k = 0; k < 6; k++) begin
         int c;
         c = k % 2;
         stim.delete();
         push_rand_bits(int'($urandom_range(0, 12)));
         repeat (3) begin
            repeat (int'($urandom_range(0, 4))) push_sym(com_of(c), sym_w(c));
            push_sym(rand_sym(c), sym_w(c));
         end
         repeat (SC) push_sym(com_of(c), sym_w(c));
         repeat (30) push_sym(rand_sym(c), sym_w(c));
         run(c, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
